// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches MULT/DIV results into shadow registers
// at issue, holds busy for a fixed latency, then commits them to the HI/LO registers.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    typedef enum logic [2:0] {
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
    } op_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi_res, r_lo_res, r_hi, r_lo;
    logic        r_div0;

    logic        w_accept, w_done;
    logic [63:0] w_prod;
    logic        w_signed, w_neg_a, w_neg_b, w_div0;
    logic [31:0] w_mag_a, w_mag_b, w_q_mag, w_r_mag, w_quot, w_rem;

    assign w_accept = (r_state == IDLE) && start && !req;
    assign w_done   = (r_state != IDLE) && (r_cnt == 4'd0);

    // One 64x64 multiplier serves both flavours; only the extension bits differ.
    assign w_signed = ~op[0];
    assign w_prod   = {{32{w_signed & rs[31]}}, rs} * {{32{w_signed & rt[31]}}, rt};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_neg_a = w_signed & rs[31];
    assign w_neg_b = w_signed & rt[31];
    assign w_mag_a = w_neg_a ? -rs : rs;
    assign w_mag_b = w_neg_b ? -rt : rt;
    assign w_div0  = (rt == 32'd0);
    assign w_q_mag = w_div0 ? '0 : w_mag_a / w_mag_b;
    assign w_r_mag = w_div0 ? '0 : w_mag_a % w_mag_b;
    assign w_quot  = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_neg_a ? -w_r_mag : w_r_mag;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && (op == OP_MULT || op == OP_MULTU)) begin
                    w_state_nxt = MUL;
                    w_cnt_nxt   = 4'(MULT_CYCLES - 1);
                end else if (w_accept && (op == OP_DIV || op == OP_DIVU)) begin
                    w_state_nxt = DIV;
                    w_cnt_nxt   = 4'(DIV_CYCLES - 1);
                end
            end
            MUL, DIV: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi_res <= '0;
            r_lo_res <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div0   <= 1'b0;
        end else begin
            if (w_accept) begin
                case (op)
                    OP_MULT, OP_MULTU: {r_hi_res, r_lo_res} <= w_prod;
                    OP_DIV, OP_DIVU: begin
                        r_hi_res <= w_rem;
                        r_lo_res <= w_quot;
                        r_div0   <= w_div0;
                    end
                    OP_MTHI: r_hi <= rs;
                    OP_MTLO: r_lo <= rs;
                    default: ;
                endcase
            end
            if (w_done && !(r_state == DIV && r_div0)) begin
                r_hi <= r_hi_res;
                r_lo <= r_lo_res;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign stall = busy | (start & ~op[2]);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed HI/LO results, busy-window length,
// flush/reset behaviour and back-to-back issue.
module tb_mdu_ctrl;

    logic        clk, reset, start, req;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .req(req), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // poke_kind 1: MTLO issued at busy cycle poke_at; 2: req pulse at busy cycle poke_at
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned n,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int unsigned poke_at, input int unsigned poke_kind);
        start = 1'b1; op = o; rs = a; rt = b;
        #1 chk1({tag, ":stall_issue"}, stall, 1'b1);
        step();
        start = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            chk1({tag, ":busy"}, busy, 1'b1);
            chk1({tag, ":stall_busy"}, stall, 1'b1);
            chk({tag, ":hi_hold"}, hi, m_hi);
            chk({tag, ":lo_hold"}, lo, m_lo);
            if (i == poke_at && poke_kind == 1) begin
                start = 1'b1; op = 3'd5; rs = 32'hDEADBEEF;
            end
            if (i == poke_at && poke_kind == 2) req = 1'b1;
            step();
            start = 1'b0; req = 1'b0;
        end
        chk1({tag, ":busy_end"}, busy, 1'b0);
        chk({tag, ":hi"}, hi, eh);
        chk({tag, ":lo"}, lo, el);
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; req = 1'b0; op = 3'd0; rs = '0; rt = '0;
        m_hi = '0; m_lo = '0;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        #10 reset = 1'b1;
        step();

        run_op("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 0, 0);
        run_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_op("divu0", 3'd3, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0, 0);
        run_op("divneg", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 0, 0);

        // MTHI commits at its own edge without busy
        start = 1'b1; op = 3'd4; rs = 32'h12345678;
        #1 chk1("mthi_stall", stall, 1'b0);
        step();
        start = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk1("mthi_busy", busy, 1'b0);
        m_hi = 32'h12345678;

        run_op("mult_mtlo", 3'd0, 32'd5, 32'd6, 5, 32'h0, 32'h0000001E, 2, 1);

        // flush blocks acceptance
        start = 1'b1; op = 3'd0; rs = 32'd2; rt = 32'd2; req = 1'b1;
        step();
        start = 1'b0; req = 1'b0;
        chk1("req_busy", busy, 1'b0);
        step();
        chk1("req_busy2", busy, 1'b0);
        chk("req_hi", hi, m_hi);
        chk("req_lo", lo, m_lo);

        // reserved opcode
        start = 1'b1; op = 3'd6; rs = 32'hFFFF0000;
        #1 chk1("rsv_stall", stall, 1'b0);
        step();
        start = 1'b0;
        chk1("rsv_busy", busy, 1'b0);
        chk("rsv_hi", hi, m_hi);
        chk("rsv_lo", lo, m_lo);

        run_op("div_req", 3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14, 3, 2);

        // MULT with start held; DIVU taken at the edge after completion
        start = 1'b1; op = 3'd0; rs = 32'd7; rt = 32'd8;
        #1 chk1("b2b_stall0", stall, 1'b1);
        step();
        op = 3'd3; rs = 32'd200; rt = 32'd9;
        for (int unsigned i = 1; i <= 5; i++) begin
            chk1("b2b_mbusy", busy, 1'b1);
            chk1("b2b_mstall", stall, 1'b1);
            step();
        end
        chk1("b2b_gap_busy", busy, 1'b0);
        chk1("b2b_gap_stall", stall, 1'b1);
        chk("b2b_mhi", hi, 32'h0);
        chk("b2b_mlo", lo, 32'h38);
        step();
        start = 1'b0;
        for (int unsigned i = 1; i <= 10; i++) begin
            chk1("b2b_dbusy", busy, 1'b1);
            chk("b2b_dlo_hold", lo, 32'h38);
            step();
        end
        chk1("b2b_dbusy_end", busy, 1'b0);
        chk("b2b_dhi", hi, 32'd2);
        chk("b2b_dlo", lo, 32'd22);

        // reset at busy cycle 3 of MULT
        start = 1'b1; op = 3'd0; rs = 32'd3; rt = 32'd4;
        step();
        start = 1'b0;
        step();
        step();
        chk1("rstmid_busy_pre", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("rstmid_busy", busy, 1'b0);
        chk("rstmid_hi", hi, 32'h0);
        chk("rstmid_lo", lo, 32'h0);
        #2 reset = 1'b1;
        repeat (8) step();
        chk1("rstmid_busy_after", busy, 1'b0);
        chk("rstmid_hi_after", hi, 32'h0);
        chk("rstmid_lo_after", lo, 32'h0);

        // first edge after release accepts
        #1 reset = 1'b0;
        start = 1'b1; op = 3'd5; rs = 32'hA5A5A5A5;
        #2 reset = 1'b1;
        step();
        start = 1'b0;
        chk("rel_lo", lo, 32'hA5A5A5A5);
        chk1("rel_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
